// File: rtl/aes_inv_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES inverse cipher.
// Byte k of a 128-bit block sits at bits [127-8k -: 8]; byte k is row k%4, column k/4.
package aes_inv_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_e;

    // MSB bit position of the byte at (row, col) in the column-major block layout.
    function automatic logic [6:0] byte_msb(input int unsigned row, input int unsigned col);
        return 7'(127 - 8 * (4 * col + row));
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Row r rotates right by r byte positions.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[byte_msb(r, c) -: 8] = s[byte_msb(r, (c + 4 - r) % 4) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
                mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
                mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
                mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
    endfunction

    function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[7'(127 - 32 * c) -: 32] = inv_mix_col(s[7'(127 - 32 * c) -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out, 256-entry table.
module aes_inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign y_o = INV_SBOX[a_i];

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES inverse cipher: one round per round key accepted from an external key store.
// Round keys are requested from index NR down to 0; the final round skips InvMixColumns.
module aes_inv_cipher_core
    import aes_inv_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         ld_i,
    input  logic [127:0] text_in_i,
    output logic         rk_req_o,
    output logic [3:0]   rk_idx_o,
    input  logic         rk_vld_i,
    input  logic [127:0] rk_data_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] text_out_o
);

    if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_check
        $error("aes_inv_cipher_core: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR_IDX = 4'(NR);

    state_e       state_q;
    logic [127:0] st_q;
    logic [127:0] text_out_q;
    logic [3:0]   idx_q;
    logic         busy_q;
    logic         done_q;

    logic [127:0] isr_d;
    logic [127:0] isb_d;
    logic [127:0] ark_d;
    logic [127:0] round_d;

    assign isr_d = inv_shift_rows(st_q);

    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .a_i (isr_d[127-8*gi -: 8]),
            .y_o (isb_d[127-8*gi -: 8])
        );
    end

    assign ark_d   = isb_d ^ rk_data_i;
    assign round_d = inv_mix_cols(ark_d);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            st_q       <= '0;
            text_out_q <= '0;
            idx_q      <= NR_IDX;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_i) begin
                        st_q    <= text_in_i;
                        idx_q   <= NR_IDX;
                        busy_q  <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    // Without a valid key every register holds; wait states are unbounded.
                    if (rk_vld_i) begin
                        if (idx_q == NR_IDX) begin
                            st_q <= st_q ^ rk_data_i;
                        end else if (idx_q != 4'd0) begin
                            st_q <= round_d;
                        end
                        if (idx_q == 4'd0) begin
                            text_out_q <= ark_d;
                            done_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            idx_q <= idx_q - 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign rk_req_o   = busy_q;
    assign busy_o     = busy_q;
    assign rk_idx_o   = idx_q;
    assign done_o     = done_q;
    assign text_out_o = text_out_q;

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Bench for aes_inv_cipher_core: NR=10 and NR=14 instances, FIPS-197 vectors and random blocks
// checked against a reference model built from GF(2^8) arithmetic and a bench-side key expansion.
module tb_aes_inv_cipher_core;

    logic clk;
    logic rst_n;
    int   sel;
    bit   vld_tie;
    logic vld_drv, ld_drv;
    logic [127:0] text_in, rk_data;

    logic req10, busy10, done10, req14, busy14, done14;
    logic [3:0] idx10, idx14;
    logic [127:0] out10, out14;
    logic ld10, ld14, vld10, vld14;

    logic req_m, busy_m, done_m;
    logic [3:0] idx_m;
    logic [127:0] out_m;

    logic [127:0] rk_tab [0:15];
    logic [7:0] sb [256];
    logic [7:0] isb [256];

    int total = 0;
    int bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ld10  = (sel == 0) && ld_drv;
    assign ld14  = (sel == 1) && ld_drv;
    assign vld10 = (sel == 0) && (vld_tie ? req10 : vld_drv);
    assign vld14 = (sel == 1) && (vld_tie ? req14 : vld_drv);

    assign req_m  = (sel == 0) ? req10  : req14;
    assign busy_m = (sel == 0) ? busy10 : busy14;
    assign done_m = (sel == 0) ? done10 : done14;
    assign idx_m  = (sel == 0) ? idx10  : idx14;
    assign out_m  = (sel == 0) ? out10  : out14;
    assign rk_data = rk_tab[idx_m];

    aes_inv_cipher_core #(.NR(10)) u_dut10 (
        .clk_i(clk), .rst_ni(rst_n), .ld_i(ld10), .text_in_i(text_in),
        .rk_req_o(req10), .rk_idx_o(idx10), .rk_vld_i(vld10), .rk_data_i(rk_data),
        .busy_o(busy10), .done_o(done10), .text_out_o(out10)
    );

    aes_inv_cipher_core #(.NR(14)) u_dut14 (
        .clk_i(clk), .rst_ni(rst_n), .ld_i(ld14), .text_in_i(text_in),
        .rk_req_o(req14), .rk_idx_o(idx14), .rk_vld_i(vld14), .rk_data_i(rk_data),
        .busy_o(busy14), .done_o(done14), .text_out_o(out14)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-boxes derived from the field inverse and the affine map, not copied from a table.
    task automatic build_sboxes();
        logic [7:0] inv, b, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            sb[x] = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic load_keys(input logic [255:0] key, input int nr);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0] rc;
        int nk;
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r < 16; r++) rk_tab[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // Textbook InvCipher on a 4x4 byte matrix using the round keys in rk_tab.
    function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input int nr);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] base [4];
        logic [127:0] k, o;
        base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] = ct[127-8*(4*c+r) -: 8];
        for (int rnd = nr; rnd >= 0; rnd--) begin
            if (rnd != nr) begin
                for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) t[r][c] = isb[s[r][(c + 4 - r) % 4]];
                s = t;
            end
            k = rk_tab[rnd];
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ k[127-8*(4*c+r) -: 8];
            if (rnd != nr && rnd != 0) begin
                for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
                    t[r][c] = 8'h00;
                    for (int j = 0; j < 4; j++) t[r][c] = t[r][c] ^ gmul(base[(j + 4 - r) % 4], s[j][c]);
                end
                s = t;
            end
        end
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Starts a block in the current cycle (called #1 after a rising edge) and serves keys until done.
    task automatic run_block(input logic [127:0] ct, input bit rnd, input bit poke_ld, input bit poke_rst,
                             input int nr, output logic [127:0] res, output int lat,
                             output bit got_done, output bit seq_ok, output bit busy_ok);
        int wait_cnt, n, exp_idx;
        bit poked;
        text_in = ct;
        ld_drv = 1'b1;
        vld_drv = 1'b0;
        wait_cnt = rnd ? int'($urandom_range(0, 5)) : 0;
        n = 0; lat = 0; exp_idx = nr; poked = 0;
        got_done = 0; seq_ok = 1; busy_ok = 1;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            ld_drv = 1'b0;
            text_in = rand128();
            if (done_m) begin
                got_done = 1;
                lat = n;
                break;
            end
            if (!busy_m || !req_m) busy_ok = 0;
            if (poke_rst && req_m && idx_m == 4'd3) begin
                rst_n = 1'b0;
                break;
            end
            if (poke_ld && !poked && req_m && idx_m == 4'd5) begin
                ld_drv = 1'b1;
                text_in = ~ct;
                poked = 1;
            end
            if (wait_cnt > 0) begin
                vld_drv = 1'b0;
                wait_cnt--;
            end else begin
                vld_drv = 1'b1;
                if (int'(idx_m) != exp_idx) seq_ok = 0;
                exp_idx--;
                wait_cnt = rnd ? int'($urandom_range(0, 5)) : 0;
            end
        end
        if (got_done && exp_idx != -1) seq_ok = 0;
        res = out_m;
        $display("blk nr=%0d ct=%h out=%h cycles=%0d done=%0d", nr, ct, res, lat, got_done);
    endtask

    typedef struct {
        int           nr;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs [3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res, res2, exp;
        logic [127:0] c1_ct, c1_pt;
        logic [255:0] c1_key, rkey;
        int lat, lat2, nr;
        bit got, got2, seq_ok, busy_ok, rnd;
        time t1, t2;

        c1_key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        c1_ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        c1_pt  = 128'h00112233445566778899aabbccddeeff;
        vecs[0] = '{10, c1_key, c1_ct, c1_pt};
        vecs[1] = '{10, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{14, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089, c1_pt};

        build_sboxes();
        sel = 0; vld_tie = 1; ld_drv = 0; vld_drv = 0; text_in = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out10", out10, 0);
        check("rst_idx10", idx10, 10);
        check("rst_ctl10", {req10, busy10, done10}, 0);
        check("rst_out14", out14, 0);
        check("rst_idx14", idx14, 14);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer vectors with rk_vld tied to rk_req.
        for (int v = 0; v < 3; v++) begin
            sel = (vecs[v].nr == 10) ? 0 : 1;
            load_keys(vecs[v].key, vecs[v].nr);
            vld_tie = 1;
            run_block(vecs[v].ct, 0, 0, 0, vecs[v].nr, res, lat, got, seq_ok, busy_ok);
            check($sformatf("kat%0d_done", v), got, 1);
            check($sformatf("kat%0d_pt", v), res, vecs[v].pt);
            check($sformatf("kat%0d_lat", v), lat, vecs[v].nr + 2);
            check($sformatf("kat%0d_idxseq", v), seq_ok, 1);
            check($sformatf("kat%0d_busy", v), busy_ok, 1);
            vld_drv = 1'b1;
            @(posedge clk); #1;
            check($sformatf("kat%0d_single_pulse", v), done_m, 0);
            check($sformatf("kat%0d_hold", v), out_m, vecs[v].pt);
            vld_drv = 1'b0;
        end

        // Random wait states on the key handshake.
        sel = 0;
        load_keys(c1_key, 10);
        vld_tie = 0;
        run_block(c1_ct, 1, 0, 0, 10, res, lat, got, seq_ok, busy_ok);
        check("wait_pt", res, c1_pt);
        check("wait_idxseq", seq_ok, 1);
        check("wait_busy", busy_ok, 1);

        // ld during FETCH is ignored.
        vld_tie = 1;
        run_block(c1_ct, 0, 1, 0, 10, res, lat, got, seq_ok, busy_ok);
        check("ldpoke_pt", res, c1_pt);
        check("ldpoke_lat", lat, 12);

        // Reset at rk_idx==3 clears outputs immediately and never yields done.
        run_block(c1_ct, 0, 0, 1, 10, res, lat, got, seq_ok, busy_ok);
        #1;
        check("rstmid_out", out_m, 0);
        check("rstmid_idx", idx_m, 10);
        check("rstmid_ctl", {req_m, busy_m, done_m}, 0);
        got2 = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done_m) got2 = 1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (done_m) got2 = 1;
        check("rstmid_nodone", got2, 0);
        run_block(c1_ct, 0, 0, 0, 10, res, lat, got, seq_ok, busy_ok);
        check("rstmid_after_pt", res, c1_pt);

        // Back-to-back: second ld in the done cycle.
        @(posedge clk); #1;
        run_block(c1_ct, 0, 0, 0, 10, res, lat, got, seq_ok, busy_ok);
        t1 = $time;
        run_block(c1_ct, 0, 0, 0, 10, res2, lat2, got2, seq_ok, busy_ok);
        t2 = $time;
        check("b2b_pt1", res, c1_pt);
        check("b2b_pt2", res2, c1_pt);
        check("b2b_done2", got2, 1);
        check("b2b_gap", t2 - t1, 128'd120);

        // Random keys and ciphertexts against the reference model.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            sel = i % 2;
            nr = (sel == 0) ? 10 : 14;
            rkey = {rand128(), rand128()};
            load_keys(rkey, nr);
            text_in = rand128();
            exp = model_decrypt(text_in, nr);
            rnd = 1'($urandom_range(0, 1));
            vld_tie = !rnd;
            run_block(text_in, rnd, 0, 0, nr, res, lat, got, seq_ok, busy_ok);
            check($sformatf("rand%0d_pt", i), res, exp);
            check($sformatf("rand%0d_idxseq", i), seq_ok, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
